// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through buffer of {PC+4, instruction} pairs
// between the program counter / instruction memory and the decode stage.
// Fetches are accepted through PCWrite, handed to decode under a
// valid/ready handshake, and all in-flight fetches are dropped on Flush.

// One storage slot. Cleared on reset; flush leaves the contents alone
// because the pointers and count already hide stale data.
module fetch_queue_entry #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  // Slot register: reset clears, write-enable loads
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (we) q <= din;
  end

endmodule

module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [31:0]            PC,
  input  logic [31:0]            Instruction,
  input  logic                   FetchValid,
  input  logic                   Flush,
  input  logic                   DecodeReady,
  output logic                   PCWrite,
  output logic [31:0]            InstrOut,
  output logic [31:0]            PCPlus4Out,
  output logic                   OutValid,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  entry_t             wdata;
  entry_t             head;
  logic [DEPTH-1:0]   we;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Full/empty come from the current count only, so a pop in the same
  // cycle never opens room for a push while full.
  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    push  = FetchValid && !full && !Flush;
    pop   = !empty && DecodeReady && !Flush;
  end

  // Build the write data; PC+4 wraps naturally at 32 bits
  always_comb begin
    wdata          = '0;
    wdata.pc_plus4 = PC + 32'd4;
    wdata.instr    = Instruction;
  end

  // One-hot write enable for the slot under the write pointer
  always_comb begin
    we = '0;
    if (push) we[wr_ptr] = 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_entry
      fetch_queue_entry #(.W($bits(entry_t))) u_entry (
        .clk   (Clk),
        .reset (Reset),
        .we    (we[g]),
        .din   (wdata),
        .q     (mem[g])
      );
    end
  endgenerate

  // Pointers and occupancy; reset and flush both return to empty
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head entry, zeroed when empty so decode sees a NOP
  always_comb begin
    head = empty ? '0 : mem[rd_ptr];
  end

  assign PCWrite    = push;
  assign OutValid   = !empty;
  assign InstrOut   = head.instr;
  assign PCPlus4Out = head.pc_plus4;
  assign Count      = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a random
// stream, all checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic                   Clk = 1'b0;
  logic                   Reset;
  logic [31:0]            PC;
  logic [31:0]            Instruction;
  logic                   FetchValid;
  logic                   Flush;
  logic                   DecodeReady;
  logic                   PCWrite;
  logic [31:0]            InstrOut;
  logic [31:0]            PCPlus4Out;
  logic                   OutValid;
  logic [$clog2(DEPTH):0] Count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PC          (PC),
    .Instruction (Instruction),
    .FetchValid  (FetchValid),
    .Flush       (Flush),
    .DecodeReady (DecodeReady),
    .PCWrite     (PCWrite),
    .InstrOut    (InstrOut),
    .PCPlus4Out  (PCPlus4Out),
    .OutValid    (OutValid),
    .Count       (Count)
  );

  always #5 Clk = ~Clk;

  // Reference model: queue of {pc_plus4, instr}
  logic [63:0] mq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        pcw_obs;
  logic        pcw_exp;

  function automatic logic [68:0] exp_out();
    logic [31:0] p4, ins;
    p4  = (mq.size() != 0) ? mq[0][63:32] : 32'd0;
    ins = (mq.size() != 0) ? mq[0][31:0]  : 32'd0;
    return {4'(mq.size()), 1'(mq.size() != 0), p4, ins};
  endfunction

  function automatic logic [68:0] obs_out();
    return {4'(Count), OutValid, PCPlus4Out, InstrOut};
  endfunction

  // Drive one cycle, sample PCWrite before the edge, advance the model
  task automatic cycle(input logic rs, input logic fl, input logic fv,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic dr);
    logic psh, pp;
    Reset = rs; Flush = fl; FetchValid = fv; PC = pc;
    Instruction = ins; DecodeReady = dr;
    #2;
    pcw_obs = PCWrite;
    pcw_exp = fv && !fl && (mq.size() < DEPTH);
    psh = pcw_exp;
    pp  = (mq.size() != 0) && dr && !fl;
    @(posedge Clk);
    if (rs || fl) mq.delete();
    else begin
      if (pp)  void'(mq.pop_front());
      if (psh) mq.push_back({pc + 32'd4, ins});
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 1, 32'h40, 32'hDEADBEEF, 0);
      if (i > 0) begin
        n_cmp++;
        if (pcw_obs !== pcw_exp) begin
          n_err++; $display("FAIL reset_pcwrite got=%b want=%b", pcw_obs, pcw_exp);
        end
      end
      n_cmp++;
      if (obs_out() !== 69'd0) begin
        n_err++; $display("FAIL reset_outputs got=%h want=0", obs_out());
      end
    end
    cycle(0, 0, 1, 32'h100, 32'h12345678, 0);
    n_cmp++;
    if (obs_out() !== {4'd1, 1'b1, 32'h104, 32'h12345678}) begin
      n_err++; $display("FAIL reset_first_push got=%h want=%h", obs_out(),
                        {4'd1, 1'b1, 32'h104, 32'h12345678});
    end
  endtask

  task automatic test_streaming();
    logic [31:0] ins[3];
    ins[0] = 32'h20080005; ins[1] = 32'h20090003; ins[2] = 32'h01095020;
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 32'(4 * i), ins[i], 1);
      n_cmp++;
      if (obs_out() !== {4'd1, 1'b1, 32'(4 * i + 4), ins[i]}) begin
        n_err++; $display("FAIL stream_%0d got=%h want=%h", i, obs_out(),
                          {4'd1, 1'b1, 32'(4 * i + 4), ins[i]});
      end
    end
  endtask

  task automatic test_fill();
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 32'h1000 + 32'(4 * i), $urandom, 0);
      n_cmp++;
      if (pcw_obs !== (i < 4)) begin
        n_err++; $display("FAIL fill_pcwrite_%0d got=%b want=%b", i, pcw_obs, (i < 4));
      end
      n_cmp++;
      if (obs_out() !== exp_out() || Count !== 3'(i < 4 ? i + 1 : 4)) begin
        n_err++; $display("FAIL fill_state_%0d got=%h want=%h", i, obs_out(), exp_out());
      end
    end
    cycle(0, 0, 1, 32'h2000, 32'hCAFEF00D, 1);
    n_cmp++;
    if (pcw_obs !== 1'b0 || Count !== 3'd3 || PCPlus4Out !== 32'h1008) begin
      n_err++; $display("FAIL full_pop got pcw=%b cnt=%0d pc4=%h want pcw=0 cnt=3 pc4=00001008",
                        pcw_obs, Count, PCPlus4Out);
    end
  endtask

  task automatic test_flush();
    cycle(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h300 + 32'(4 * i), $urandom, 0);
    n_cmp++;
    if (Count !== 3'd3) begin
      n_err++; $display("FAIL flush_pre got=%0d want=3", Count);
    end
    cycle(0, 1, 1, 32'h400, 32'h11111111, 1);
    n_cmp++;
    if (pcw_obs !== 1'b0 || obs_out() !== 69'd0) begin
      n_err++; $display("FAIL flush got pcw=%b out=%h want pcw=0 out=0", pcw_obs, obs_out());
    end
    cycle(0, 0, 1, 32'h500, 32'h22222222, 0);
    n_cmp++;
    if (pcw_obs !== 1'b1 || obs_out() !== {4'd1, 1'b1, 32'h504, 32'h22222222}) begin
      n_err++; $display("FAIL flush_after got pcw=%b out=%h", pcw_obs, obs_out());
    end
  endtask

  task automatic test_wrap();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h800, $urandom, 1);
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0, 1, 32'h800 + 32'(4 * i), $urandom, 1);
      n_cmp++;
      if (obs_out() !== exp_out() || PCPlus4Out !== 32'h804 + 32'(4 * i)) begin
        n_err++; $display("FAIL wrap_%0d got=%h want=%h", i, obs_out(), exp_out());
      end
    end
  endtask

  task automatic test_pc_wrap();
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'hFFFFFFFC, 32'h00000013, 0);
    n_cmp++;
    if (PCPlus4Out !== 32'h0 || OutValid !== 1'b1 || InstrOut !== 32'h13) begin
      n_err++; $display("FAIL pc_wrap got pc4=%h vld=%b want pc4=00000000 vld=1",
                        PCPlus4Out, OutValid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0),
            1'($urandom), $urandom, $urandom, 1'($urandom));
      n_cmp++;
      if (pcw_obs !== pcw_exp) begin
        n_err++; $display("FAIL rand_pcwrite_%0d got=%b want=%b", i, pcw_obs, pcw_exp);
      end
      n_cmp++;
      if (obs_out() !== exp_out()) begin
        n_err++; $display("FAIL rand_out_%0d got=%h want=%h", i, obs_out(), exp_out());
      end
    end
  endtask

  initial begin
    Reset = 1; Flush = 0; FetchValid = 0; PC = 0; Instruction = 0; DecodeReady = 0;
    test_reset();
    test_streaming();
    test_fill();
    test_flush();
    test_wrap();
    test_pc_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
